// File: rtl/lpf_sequencer.sv
// Sample sequencer: tick -> ADC request/ack -> one-cycle filter enable -> registered y_data/y_valid (ack edge + 2).
// Define LPF_SEQ_TIMEOUT_EN to abort a request after TIMEOUT cycles without adc_ack and raise timeout_err.
module lpf_sequencer #(
    parameter int Width   = 10,
    parameter int CLK_DIV = 20000,
    parameter int WARMUP  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             adc_req,
    input  logic             adc_ack,
    input  logic [Width-1:0] adc_data,
    output logic             lpf_en,
    output logic [Width-1:0] lpf_x,
    input  logic [Width-1:0] lpf_y,
    output logic             y_valid,
    output logic [Width-1:0] y_data,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int TW = $clog2(CLK_DIV);
    localparam logic [7:0] WARM8 = 8'(WARMUP);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILT, S_EMIT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TW-1:0]    r_tick_cnt;
    logic [7:0]       r_smp_cnt;
    logic             r_adc_req;
    logic             r_lpf_en;
    logic [Width-1:0] r_lpf_x;
    logic             r_y_valid;
    logic [Width-1:0] r_y_data;
    logic             r_busy;
    logic             r_overrun;

    logic             w_tick;
    logic             w_adc_req_nxt;
    logic             w_lpf_en_nxt;
    logic             w_y_valid_nxt;
    logic             w_latch_x;
    logic             w_emit;
    logic [7:0]       w_cnt_inc;
`ifdef LPF_SEQ_TIMEOUT_EN
    logic [15:0]      r_to_cnt;
    logic             r_timeout_err;
    logic             w_to_fire;
`endif

    // tick is gated by run so a stale count can never start or drop a sample
    assign w_tick    = run && (r_tick_cnt == TW'(CLK_DIV - 1));
    assign w_cnt_inc = (r_smp_cnt == 8'hFF) ? 8'hFF : r_smp_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_adc_req_nxt = 1'b0;
        w_lpf_en_nxt  = 1'b0;
        w_y_valid_nxt = 1'b0;
        w_latch_x     = 1'b0;
        w_emit        = 1'b0;
`ifdef LPF_SEQ_TIMEOUT_EN
        w_to_fire     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nxt   = S_REQ;
                    w_adc_req_nxt = 1'b1;
                end
            end
            S_REQ: begin
                if (!run) begin
                    w_state_nxt = S_IDLE;
                end else if (adc_ack) begin
                    w_state_nxt  = S_FILT;
                    w_lpf_en_nxt = 1'b1;
                    w_latch_x    = 1'b1;
`ifdef LPF_SEQ_TIMEOUT_EN
                end else if (r_to_cnt == 16'(TIMEOUT - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_to_fire   = 1'b1;
`endif
                end else begin
                    w_adc_req_nxt = 1'b1;
                end
            end
            S_FILT: begin
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                w_state_nxt   = S_IDLE;
                w_emit        = 1'b1;
                w_y_valid_nxt = (w_cnt_inc > WARM8);
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_adc_req <= 1'b0;
            r_lpf_en  <= 1'b0;
            r_lpf_x   <= '0;
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_smp_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_adc_req <= w_adc_req_nxt;
            r_lpf_en  <= w_lpf_en_nxt;
            r_y_valid <= w_y_valid_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_latch_x) begin
                r_lpf_x <= adc_data;
            end
            if (w_emit) begin
                r_y_data <= lpf_y;
            end
            if (!run) begin
                r_smp_cnt <= '0;
            end else if (w_emit) begin
                r_smp_cnt <= w_cnt_inc;
            end
            if (w_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef LPF_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_REQ) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_to_fire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    assign adc_req = r_adc_req;
    assign lpf_en  = r_lpf_en;
    assign lpf_x   = r_lpf_x;
    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_lpf_sequencer.sv
// Bench for lpf_sequencer: directed ADC/filter handshakes, y_data checked by a queue-based scoreboard.
module tb_lpf_sequencer;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              adc_req;
    logic              adc_ack;
    logic signed [9:0] adc_data;
    logic              lpf_en;
    logic signed [9:0] lpf_x;
    logic signed [9:0] lpf_y;
    logic              y_valid;
    logic signed [9:0] y_data;
    logic              busy;
    logic              overrun;
    logic              timeout_err;

    typedef struct {
        int dat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   en_cnt  = 0;
    int   en_exp  = 0;

    lpf_sequencer #(
        .Width(10), .CLK_DIV(32), .WARMUP(2), .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
        .lpf_en(lpf_en), .lpf_x(lpf_x), .lpf_y(lpf_y),
        .y_valid(y_valid), .y_data(y_data), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (lpf_en) en_cnt <= en_cnt + 1;

    // external filter: y <= (y + x) / 2 on each enable
    always @(posedge clk) begin
        if (rst) begin
            lpf_y <= '0;
        end else if (lpf_en) begin
            lpf_y <= 10'(($signed({lpf_y[9], lpf_y}) + $signed({lpf_x[9], lpf_x})) >>> 1);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (y_valid) begin
            if (sb.size() == 0) begin
                chk("y_valid_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("y_data_sb", y_data, mon_e.dat);
                chk("y_valid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_req && n < 100);
        if (!adc_req) chk("req_wait", adc_req, 1);
    endtask

    task automatic do_sample(input int d, input int exp_y, input bit exp_vld);
        int n;
        int a;
        wait_req(n);
        repeat (3) @(negedge clk);
        adc_ack  = 1'b1;
        adc_data = 10'(d);
        @(posedge clk);
        #1 a = cyc;
        if (exp_vld) sb.push_back('{dat: exp_y, cyc: a + 2});
        @(negedge clk);
        adc_ack = 1'b0;
        chk("lpf_x_latch", lpf_x, d);
        chk("req_drop", adc_req, 0);
        chk("en_filt", lpf_en, 1);
        en_exp++;
        repeat (2) @(negedge clk);
        chk("y_data", y_data, exp_y);
        chk("busy_idle", busy, 0);
        chk("en_count", en_cnt, en_exp);
    endtask

    task automatic chk_reset_vals();
        chk("rst_adc_req", adc_req, 0);
        chk("rst_lpf_en", lpf_en, 0);
        chk("rst_lpf_x", lpf_x, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_data", y_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout_err", timeout_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  hi;
        bit  busy_all;
        bit  req_all;
        logic ovr31;

        rst      = 1'b1;
        run      = 1'b0;
        adc_ack  = 1'b0;
        adc_data = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        run = 1'b1;

        // warm-up: first two samples silent, third emitted
        do_sample(100, 50, 0);
        do_sample(200, 125, 0);
        do_sample(300, 212, 1);

        // ack while idle is ignored
        @(negedge clk);
        adc_ack  = 1'b1;
        adc_data = 10'sd77;
        @(negedge clk);
        adc_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_lpf_x", lpf_x, 300);
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_req", adc_req, 0);
        chk("idle_ack_en", en_cnt, en_exp);

`ifdef LPF_SEQ_TIMEOUT_EN
        wait_req(n);
        hi = 1;
        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            if (!adc_req) break;
            hi++;
        end
        chk("timeout_req_cycles", hi, 10);
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_en", en_cnt, en_exp);
        chk("timeout_no_ovr", overrun, 0);
        wait_req(n);
        chk("rereq_latency", n, 22);
`else
        wait_req(n);
        busy_all = 1'b1;
        req_all  = 1'b1;
        ovr31    = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!busy) busy_all = 1'b0;
            if (!adc_req) req_all = 1'b0;
            if (i == 31) ovr31 = overrun;
        end
        chk("ovr_before_tick", ovr31, 0);
        chk("ovr_after_tick", overrun, 1);
        chk("hold_busy", busy_all, 1);
        chk("hold_req", req_all, 1);
        chk("no_timeout_err", timeout_err, 0);
        chk("hold_no_en", en_cnt, en_exp);
`endif

        // run=0 in REQ aborts; warm-up applies again afterwards
        run = 1'b0;
        @(negedge clk);
        chk("abort_req", adc_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_no_en", en_cnt, en_exp);
        @(negedge clk);
        run = 1'b1;
        do_sample(40, 126, 0);
        do_sample(-60, 33, 0);
        do_sample(20, 26, 1);

        // reset during FILT
        wait_req(n);
        repeat (3) @(negedge clk);
        adc_ack  = 1'b1;
        adc_data = 10'sd50;
        @(posedge clk);
        @(negedge clk);
        adc_ack = 1'b0;
        chk("pre_rst_en", lpf_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals();
        wait_req(n);
        chk("restart_latency", n, 32);

        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lpf_sequencer.md
LPF_SEQUENCER -- requirements
Module: lpf_sequencer

Interface
REQ-001 Parameter Width, default 10, SHALL set the signed sample width of adc_data, lpf_x, lpf_y and y_data.
REQ-002 Parameter CLK_DIV, default 20000, SHALL set the clk cycles per sample period; legal values are >= 8.
REQ-003 Parameter WARMUP, default 16, SHALL set the number of filtered samples discarded after run rises; legal range is 0..255.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the ADC acknowledge limit in clk cycles; legal range is 1..65535.
REQ-005 clk  in  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-006 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-007 run  in  1  SHALL enable sampling while high.
REQ-008 adc_req  out  1  SHALL request one ADC conversion.
REQ-009 adc_ack  in  1  SHALL mark adc_data valid.
REQ-010 adc_data  in  Width  SHALL carry the signed ADC sample.
REQ-011 lpf_en  out  1  SHALL drive the filter enable.
REQ-012 lpf_x  out  Width  SHALL drive the filter input.
REQ-013 lpf_y  in  Width  SHALL receive the filter output.
REQ-014 y_valid  out  1  SHALL pulse when y_data is new.
REQ-015 y_data  out  Width  SHALL carry the filtered sample.
REQ-016 busy  out  1  SHALL be high whenever the FSM is not IDLE.
REQ-017 overrun  out  1  SHALL be a sticky flag for a dropped tick.
REQ-018 timeout_err  out  1  SHALL be a sticky flag for an ADC timeout.

Function
REQ-019 Tick counter: counts 0..CLK_DIV-1 while run=1, wraps, and holds 0 while run=0; tick = 1 for one cycle when count==CLK_DIV-1.
REQ-020 FSM states: IDLE, REQ, FILT, EMIT; all outputs registered.
REQ-021 IDLE -> REQ on tick with run=1; adc_req goes high on entering REQ.
REQ-022 REQ: adc_req stays high until adc_ack is sampled high; on that edge the FSM latches lpf_x <= adc_data, deasserts adc_req, and moves to FILT.
REQ-023 FILT: lpf_en is high for exactly one cycle, then the FSM moves to EMIT.
REQ-024 EMIT: y_data <= lpf_y, sample count increments (saturating at 255), FSM returns to IDLE.
REQ-025 y_valid is high for one cycle, on the second rising edge after the ack-sampling edge, only when the post-increment sample count > WARMUP; y_data is still updated while y_valid=0.
REQ-026 A tick outside IDLE is dropped and sets overrun; overrun clears only on rst.
REQ-027 run=0 while in REQ aborts to IDLE on the next edge: adc_req drops, no lpf_en pulse.
REQ-028 run=0 while in FILT or EMIT: the sample completes normally.
REQ-029 Sample count clears to 0 on any cycle with run=0.
REQ-030 adc_ack outside REQ SHALL be ignored.
REQ-031 lpf_en SHALL never assert except in FILT: at most one pulse per tick.

Reset
REQ-032 rst=1 SHALL force IDLE and clear the tick counter, sample count and timeout counter.
REQ-033 Output values under reset: adc_req=0, lpf_en=0, lpf_x=0, y_valid=0, y_data=0, busy=0, overrun=0, timeout_err=0.
REQ-034 rst asserted mid-sequence SHALL take effect on the same edge, dropping adc_req and lpf_en immediately.

Configuration
REQ-035 Macro LPF_SEQ_TIMEOUT_EN, when defined, SHALL enable the acknowledge timeout:
- A counter runs in REQ.
- If TIMEOUT cycles elapse without adc_ack, the FSM deasserts adc_req, sets timeout_err (sticky until rst), and returns to IDLE without lpf_en.
REQ-036 Without LPF_SEQ_TIMEOUT_EN, REQ SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Verification
REQ-037 Bench parameters SHALL be CLK_DIV=32, WARMUP=2, TIMEOUT=10.
REQ-038 Scenario: run=1, ADC acks 3 cycles after each req with data 100, 200, 300 -> the first two samples give no y_valid; the third gives y_valid 2 edges after ack with y_data = lpf_y; exactly one lpf_en per tick.
REQ-039 Scenario: ack withheld for 40 cycles, macro off -> adc_req stays high, the tick at cycle 32 is dropped, overrun=1, busy=1 throughout.
REQ-040 Scenario: ack withheld, macro on -> adc_req falls after 10 cycles, timeout_err=1, no lpf_en, next tick re-requests.
REQ-041 Scenario: run=0 while in REQ -> adc_req drops next edge, no lpf_en; after run=1 again, WARMUP=2 samples are suppressed again.
REQ-042 Scenario: rst pulse during FILT -> lpf_en=0 and all outputs are at reset values on the next cycle; the tick counter restarts from 0.
REQ-043 Scenario: adc_ack=1 pulsed while in IDLE -> no state change, lpf_x unchanged.
